panel_init_sequencer: RTL and testbench

Controller that owns the HUB75 panel output bus and shares it between the FM6126A init engine (`fm6126init`) and the normal row-scan pipeline. It runs the init engine after reset and again on host request or periodic timer, and only hands the bus over at a frame boundary. During the hand-over it inserts blanking guard intervals. It also reports init status and timeouts. It sits between `fm6126init`, the scan pipeline and the panel pins.

---
 rtl/panel_init_sequencer.sv | 162 ++++++++++++++++
 tb/tb_panel_init_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/panel_init_sequencer.sv
// Owns the HUB75 panel bus: runs the FM6126A init engine after reset or on request and hands the
// bus to the scan pipeline at a frame boundary, with blanking guards around every init run.
module panel_init_sequencer #(
  parameter int unsigned BLANK_CYCLES  = 16,
  parameter int unsigned INIT_TIMEOUT  = 65535,
  parameter int unsigned REINIT_PERIOD = 0,
  parameter int unsigned PERIOD_WIDTH  = 32
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       reinit_req,
  input  logic       frame_boundary,
  input  logic       scan_output_enable,
  input  logic [2:0] scan_rgb1,
  input  logic [2:0] scan_rgb2,
  input  logic       scan_latch,
  input  logic       init_output_enable,
  input  logic [2:0] init_rgb1,
  input  logic [2:0] init_rgb2,
  input  logic       init_latch,
  input  logic       init_done,
  output logic       init_reset,
  output logic       output_enable_out,
  output logic [2:0] rgb1_out,
  output logic [2:0] rgb2_out,
  output logic       latch_out,
  output logic       init_active,
  output logic       init_error,
  output logic [7:0] init_count
);

  localparam int unsigned CntMax = (BLANK_CYCLES > INIT_TIMEOUT) ? BLANK_CYCLES : INIT_TIMEOUT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] BlankLast   = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(INIT_TIMEOUT - 1);
  localparam logic [PERIOD_WIDTH-1:0] PeriodLast = PERIOD_WIDTH'(REINIT_PERIOD - 1);
  localparam bit PeriodEn = (REINIT_PERIOD != 0);
  // Bus bundle order: {oe_n, rgb1, rgb2, latch}; blank means OE deasserted, data and latch low.
  localparam logic [7:0] BlankBus = 8'b1_000_000_0;

  typedef enum logic [2:0] {
    StGuardPre,
    StInitKick,
    StInitRun,
    StGuardPost,
    StScan,
    StWaitBoundary
  } state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic                    pending_q, pending_d;
  logic                    error_q, error_d;
  logic [7:0]              count_q, count_d;
  logic [7:0]              bus_q, bus_d;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q   <= StGuardPre;
      cnt_q     <= '0;
      period_q  <= '0;
      pending_q <= 1'b0;
      error_q   <= 1'b0;
      count_q   <= '0;
      bus_q     <= BlankBus;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      pending_q <= pending_d;
      error_q   <= error_d;
      count_q   <= count_d;
      bus_q     <= bus_d;
    end
  end

  // cnt_q doubles as the guard timer and the INIT_RUN timer; zero marks the first run cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    pending_d = pending_q | reinit_req;
    error_d   = error_q;
    count_d   = count_q;
    unique case (state_q)
      StGuardPre: begin
        if (cnt_q == BlankLast) begin
          state_d = StInitKick;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StInitKick: begin
        pending_d = 1'b0;
        state_d   = StInitRun;
        cnt_d     = '0;
      end
      StInitRun: begin
        if ((cnt_q != '0) && init_done) begin
          count_d = (count_q == 8'hFF) ? count_q : count_q + 1'b1;
          state_d = StGuardPost;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutLast) begin
          error_d = 1'b1;
          state_d = StGuardPost;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGuardPost: begin
        if (cnt_q == BlankLast) begin
          state_d  = StScan;
          cnt_d    = '0;
          period_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StScan: begin
        period_d = period_q + 1'b1;
        if (PeriodEn && (period_q == PeriodLast)) begin
          pending_d = 1'b1;
        end
        if (pending_q) begin
          state_d = StWaitBoundary;
        end
      end
      StWaitBoundary: begin
        if (frame_boundary) begin
          state_d = StGuardPre;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StGuardPre;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    init_reset  = (state_q == StInitKick);
    init_active = (state_q != StScan);
    bus_d       = BlankBus;
    if ((state_q == StScan) || (state_q == StWaitBoundary)) begin
      bus_d = {scan_output_enable, scan_rgb1, scan_rgb2, scan_latch};
    end else if ((state_q == StInitRun) && (cnt_q != '0)) begin
      bus_d = {init_output_enable, init_rgb1, init_rgb2, init_latch};
    end
  end

  assign output_enable_out = bus_q[7];
  assign rgb1_out          = bus_q[6:4];
  assign rgb2_out          = bus_q[3:1];
  assign latch_out         = bus_q[0];
  assign init_error        = error_q;
  assign init_count        = count_q;

endmodule

// File: tb/tb_panel_init_sequencer.sv
// Bench for panel_init_sequencer: directed phases with randomized data and timing, expectations
// derived from phase lengths (guard, run, timeout, period) computed arithmetically.
module tb_panel_init_sequencer;

  localparam int B = 4;
  localparam int T = 100;
  localparam int P = 1000;
  localparam logic [7:0] Blank = 8'h80;

  logic       clk_in;
  logic       reset;
  logic       reinit_req;
  logic       frame_boundary;
  logic       scan_output_enable;
  logic [2:0] scan_rgb1;
  logic [2:0] scan_rgb2;
  logic       scan_latch;
  logic       init_output_enable;
  logic [2:0] init_rgb1;
  logic [2:0] init_rgb2;
  logic       init_latch;
  logic       init_done;
  logic       init_reset;
  logic       output_enable_out;
  logic [2:0] rgb1_out;
  logic [2:0] rgb2_out;
  logic       latch_out;
  logic       init_active;
  logic       init_error;
  logic [7:0] init_count;
  logic [7:0] pins;

  int         checks;
  int         failures;
  int         exp_count;
  logic       exp_error;
  logic [7:0] last_scan;
  logic [7:0] last_init;
  bit         force_vis;

  panel_init_sequencer #(
    .BLANK_CYCLES (B),
    .INIT_TIMEOUT (T),
    .REINIT_PERIOD(P),
    .PERIOD_WIDTH (32)
  ) dut (
    .clk_in            (clk_in),
    .reset             (reset),
    .reinit_req        (reinit_req),
    .frame_boundary    (frame_boundary),
    .scan_output_enable(scan_output_enable),
    .scan_rgb1         (scan_rgb1),
    .scan_rgb2         (scan_rgb2),
    .scan_latch        (scan_latch),
    .init_output_enable(init_output_enable),
    .init_rgb1         (init_rgb1),
    .init_rgb2         (init_rgb2),
    .init_latch        (init_latch),
    .init_done         (init_done),
    .init_reset        (init_reset),
    .output_enable_out (output_enable_out),
    .rgb1_out          (rgb1_out),
    .rgb2_out          (rgb2_out),
    .latch_out         (latch_out),
    .init_active       (init_active),
    .init_error        (init_error),
    .init_count        (init_count)
  );

  assign pins = {output_enable_out, rgb1_out, rgb2_out, latch_out};

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: fresh random data on both source buses, then sample 1 time unit after the edge.
  task automatic cyc();
    logic [7:0] sv;
    logic [7:0] iv;
    sv = 8'($urandom);
    iv = 8'($urandom);
    if (force_vis) iv[7] = 1'b0;
    {scan_output_enable, scan_rgb1, scan_rgb2, scan_latch} = sv;
    {init_output_enable, init_rgb1, init_rgb2, init_latch} = iv;
    @(posedge clk_in);
    #1;
    last_scan = sv;
    last_init = iv;
  endtask

  task automatic guard_pre(input int req_i);
    for (int i = 1; i <= B + 1; i++) begin
      reinit_req = (i == req_i);
      cyc();
      chk($sformatf("pre%0d.pins", i), pins, Blank);
      chk($sformatf("pre%0d.init_reset", i), init_reset, (i == B));
      chk($sformatf("pre%0d.active", i), init_active, 1'b1);
    end
    reinit_req = 1'b0;
  endtask

  // done_at: first run cycle with init_done high (0 = never); success needs run cycle >= 2.
  task automatic init_run(input int done_at, input int req_k);
    bit tmo;
    int ex;
    tmo = (done_at == 0) || (done_at > T);
    ex  = tmo ? T : ((done_at < 2) ? 2 : done_at);
    for (int k = 1; k <= ex; k++) begin
      init_done  = (done_at != 0) && (k >= done_at);
      reinit_req = (k == req_k);
      cyc();
      chk($sformatf("run%0d.pins", k), pins, (k == 1) ? Blank : last_init);
      chk($sformatf("run%0d.active", k), init_active, 1'b1);
      if (k < ex) chk($sformatf("run%0d.error", k), init_error, exp_error);
    end
    reinit_req = 1'b0;
    if (tmo) exp_error = 1'b1;
    else if (exp_count < 255) exp_count++;
    chk("run_end.error", init_error, exp_error);
    chk("run_end.count", init_count, exp_count);
  endtask

  task automatic guard_post(input int req_i);
    for (int i = 1; i <= B; i++) begin
      reinit_req = (i == req_i);
      cyc();
      chk($sformatf("post%0d.pins", i), pins, Blank);
      chk($sformatf("post%0d.active", i), init_active, (i < B));
      chk($sformatf("post%0d.init_reset", i), init_reset, 1'b0);
    end
    reinit_req = 1'b0;
  endtask

  // Scan until the bus is handed back: pending becomes visible at pend_edge, WAIT_BOUNDARY follows
  // one edge later, and only a boundary sampled strictly after that edge takes effect.
  task automatic scan_phase(input bit pre_pend, input int req_at, input int fb_per,
                            input int fb_extra);
    int pend_edge;
    int wait_edge;
    int sw;
    pend_edge = pre_pend ? 0 : (((req_at != 0) && (req_at < P)) ? req_at : P);
    wait_edge = pend_edge + 1;
    sw = wait_edge + 1;
    while (!(((fb_per != 0) && (sw % fb_per == 0)) || (sw == fb_extra)) && (sw < wait_edge + 5000))
      sw++;
    for (int e = 1; e <= sw; e++) begin
      reinit_req     = (e == req_at);
      frame_boundary = ((fb_per != 0) && (e % fb_per == 0)) || (e == fb_extra);
      cyc();
      chk($sformatf("scan%0d.pins", e), pins, last_scan);
      chk($sformatf("scan%0d.active", e), init_active, (e >= wait_edge));
    end
    reinit_req     = 1'b0;
    frame_boundary = 1'b0;
  endtask

  initial begin
    int d;
    int rk;
    int ra;
    checks     = 0;
    failures   = 0;
    exp_count  = 0;
    exp_error  = 1'b0;
    force_vis  = 1'b0;
    reset      = 1'b1;
    reinit_req = 1'b0;
    frame_boundary = 1'b0;
    init_done  = 1'b0;
    {scan_output_enable, scan_rgb1, scan_rgb2, scan_latch} = 8'h00;
    {init_output_enable, init_rgb1, init_rgb2, init_latch} = 8'h00;
    #1;
    chk("rst.pins", pins, Blank);
    chk("rst.init_reset", init_reset, 1'b0);
    chk("rst.active", init_active, 1'b1);
    chk("rst.error", init_error, 1'b0);
    chk("rst.count", init_count, 8'd0);
    repeat (2) begin
      cyc();
      chk("rst_hold.pins", pins, Blank);
    end
    reset = 1'b0;

    // Power-up run with a request absorbed during the leading guard.
    guard_pre(2);
    init_run(50, 0);
    guard_post(0);
    scan_phase(1'b0, 20, 0, 57);

    // Stale done level held throughout: run lasts exactly two cycles.
    init_done = 1'b1;
    guard_pre(0);
    init_run(1, 0);
    guard_post(0);
    ra = $urandom_range(2, 30);
    scan_phase(1'b0, ra, 0, ra + $urandom_range(2, 20));

    // Timeout run.
    guard_pre(0);
    init_run(0, 0);
    guard_post(0);
    scan_phase(1'b0, 5, 0, 12);

    // Request during INIT_RUN gives exactly one extra init.
    guard_pre(0);
    d  = $urandom_range(5, 90);
    rk = $urandom_range(1, d - 1);
    init_run(d, rk);
    guard_post(0);
    scan_phase(1'b1, 0, $urandom_range(3, 9), 0);
    guard_pre(0);
    init_run($urandom_range(2, 60), 0);
    guard_post(0);
    // Periodic re-init; the boundary in the cycle pending is first seen (1001) is missed.
    scan_phase(1'b0, 0, 77, 0);

    // Request during GUARD_POST.
    guard_pre(0);
    init_run($urandom_range(2, 60), 0);
    guard_post($urandom_range(1, B));
    scan_phase(1'b1, 0, 0, $urandom_range(2, 15));

    // Asynchronous reset in the middle of INIT_RUN.
    guard_pre(0);
    init_done = 1'b0;
    force_vis = 1'b1;
    for (int k = 1; k <= 5; k++) cyc();
    chk("mid.pins", pins, last_init);
    #3;
    reset = 1'b1;
    #1;
    chk("async.pins", pins, Blank);
    chk("async.active", init_active, 1'b1);
    chk("async.init_reset", init_reset, 1'b0);
    chk("async.error", init_error, 1'b0);
    chk("async.count", init_count, 8'd0);
    @(posedge clk_in);
    #1;
    reset     = 1'b0;
    force_vis = 1'b0;
    exp_count = 0;
    exp_error = 1'b0;
    guard_pre(0);
    init_run($urandom_range(2, 40), 0);
    guard_post(0);
    scan_phase(1'b0, 3, 0, 8);

    // Quick back-to-back inits to drive the success count into saturation.
    for (int n = 0; n < 256; n++) begin
      init_done = 1'b1;
      guard_pre(0);
      init_run(1, 0);
      guard_post(0);
      scan_phase(1'b0, 1, 0, 3);
    end
    chk("sat.count", init_count, 8'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
